// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle ops raise listo 1 cycle after acceptance, MUL/DIV after ANCHO+1 cycles.
// No queueing: inicio is dropped while ocupado is high or during the listo cycle.
module alu_multiciclo #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inicio,
  input  logic [4:0]       opcode,
  input  logic [ANCHO-1:0] operando_a,
  input  logic [ANCHO-1:0] operando_b,
  output logic             ocupado,
  output logic             listo,
  output logic [ANCHO-1:0] resultado,
  output logic             C,
  output logic             S,
  output logic             O,
  output logic             Z,
  output logic             div_cero
);
  localparam int LW = $clog2(ANCHO);
  localparam logic [LW-1:0] ULTIMO = LW'(ANCHO - 1);

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;
  localparam logic [4:0] OP_NOT = 5'd6;
  localparam logic [4:0] OP_SHL = 5'd7;
  localparam logic [4:0] OP_SHR = 5'd8;
  localparam logic [4:0] OP_MUL = 5'd9;
  localparam logic [4:0] OP_DIV = 5'd10;

  typedef enum logic [1:0] {REPOSO, CALCULO, FIN} estado_t;
  estado_t estado, estado_sig;

  logic [ANCHO-1:0] oper, hi, lo, hi_sig, lo_sig, res_u;
  logic [ANCHO:0]   suma, desp, prueba;
  logic [LW-1:0]    cnt, amt;
  logic             es_div, multi, c_u, o_u, dz_u;

  assign amt   = operando_b[LW-1:0];
  assign multi = (opcode == OP_MUL) || ((opcode == OP_DIV) && (operando_b != '0));

  // Single-cycle results, taken straight from the live inputs on the accepting edge.
  always_comb begin
    res_u = '0;
    c_u   = 1'b0;
    o_u   = 1'b0;
    dz_u  = 1'b0;
    case (opcode)
      OP_ADD: begin
        {c_u, res_u} = {1'b0, operando_a} + {1'b0, operando_b};
        o_u = (operando_a[ANCHO-1] == operando_b[ANCHO-1]) && (res_u[ANCHO-1] != operando_a[ANCHO-1]);
      end
      OP_SUB: begin
        {c_u, res_u} = {1'b0, operando_a} - {1'b0, operando_b};
        o_u = (operando_a[ANCHO-1] != operando_b[ANCHO-1]) && (res_u[ANCHO-1] != operando_a[ANCHO-1]);
      end
      OP_AND: res_u = operando_a & operando_b;
      OP_OR:  res_u = operando_a | operando_b;
      OP_XOR: res_u = operando_a ^ operando_b;
      OP_NOT: res_u = ~operando_a;
      OP_SHL: {c_u, res_u} = {1'b0, operando_a} << amt;
      OP_SHR: {res_u, c_u} = {operando_a, 1'b0} >> amt;
      OP_DIV: begin
        res_u = '1;
        dz_u  = 1'b1;
      end
      default: ;
    endcase
  end

  // One iteration: hi/lo hold {product high, multiplier} for MUL, {remainder, quotient} for DIV.
  always_comb begin
    suma   = {1'b0, hi} + {1'b0, {ANCHO{lo[0]}} & oper};
    desp   = {hi, lo[ANCHO-1]};
    prueba = desp - {1'b0, oper};
    if (es_div) begin
      hi_sig = prueba[ANCHO] ? desp[ANCHO-1:0] : prueba[ANCHO-1:0];
      lo_sig = {lo[ANCHO-2:0], ~prueba[ANCHO]};
    end else begin
      hi_sig = suma[ANCHO:1];
      lo_sig = {suma[0], lo[ANCHO-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) estado <= REPOSO;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:  if (inicio) estado_sig = multi ? CALCULO : FIN;
      CALCULO: if (cnt == ULTIMO) estado_sig = FIN;
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado == CALCULO);
    listo   = (estado == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resultado <= '0;
      C         <= 1'b0;
      S         <= 1'b0;
      O         <= 1'b0;
      Z         <= 1'b0;
      div_cero  <= 1'b0;
      oper      <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      es_div    <= 1'b0;
    end else begin
      case (estado)
        REPOSO: if (inicio) begin
          if (multi) begin
            es_div <= (opcode == OP_DIV);
            oper   <= (opcode == OP_MUL) ? operando_a : operando_b;
            lo     <= (opcode == OP_MUL) ? operando_b : operando_a;
            hi     <= '0;
            cnt    <= '0;
          end else begin
            resultado <= res_u;
            C         <= c_u;
            S         <= res_u[ANCHO-1];
            O         <= o_u;
            Z         <= (res_u == '0);
            div_cero  <= dz_u;
          end
        end
        CALCULO: begin
          hi  <= hi_sig;
          lo  <= lo_sig;
          cnt <= cnt + 1'b1;
          if (cnt == ULTIMO) begin
            resultado <= lo_sig;
            C         <= 1'b0;
            S         <= lo_sig[ANCHO-1];
            O         <= ~es_div && (hi_sig != '0);
            Z         <= (lo_sig == '0);
            div_cero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multiciclo.sv
// Bench for alu_multiciclo: a 32-bit and an 8-bit instance checked against an arithmetic reference model.
module tb_alu_multiciclo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        inicio, inicio8;
  logic [4:0]  opcode, opcode8;
  logic [31:0] a, b, res;
  logic [7:0]  a8, b8, res8;
  logic        ocup, listo, c, s, o, z, dz;
  logic        ocup8, listo8, c8, s8, o8, z8, dz8;

  int checks = 0;
  int errors = 0;

  alu_multiciclo #(.ANCHO(32)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .opcode(opcode),
    .operando_a(a), .operando_b(b), .ocupado(ocup), .listo(listo),
    .resultado(res), .C(c), .S(s), .O(o), .Z(z), .div_cero(dz)
  );

  alu_multiciclo #(.ANCHO(8)) dut8 (
    .clk(clk), .reset(reset), .inicio(inicio8), .opcode(opcode8),
    .operando_a(a8), .operando_b(b8), .ocupado(ocup8), .listo(listo8),
    .resultado(res8), .C(c8), .S(s8), .O(o8), .Z(z8), .div_cero(dz8)
  );

  // Reference: plain arithmetic on w-bit unsigned values held in 64/128-bit variables.
  task automatic model(input int w, input logic [4:0] op, input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] r, output logic cf, output logic of, output logic df);
    logic [127:0] p;
    logic [63:0]  mask;
    int           amt;
    mask = (64'd1 << w) - 64'd1;
    amt  = int'(y % 64'(w));
    r = '0; cf = 1'b0; of = 1'b0; df = 1'b0;
    case (op)
      5'd1: begin
        p = 128'(x) + 128'(y); r = p[63:0] & mask; cf = p[w];
        of = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
      end
      5'd2: begin
        r = (x - y) & mask; cf = (x < y);
        of = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
      end
      5'd3: r = x & y;
      5'd4: r = x | y;
      5'd5: r = x ^ y;
      5'd6: r = ~x & mask;
      5'd7: begin p = 128'(x) << amt; r = p[63:0] & mask; cf = p[w]; end
      5'd8: begin r = x >> amt; cf = (amt == 0) ? 1'b0 : x[amt-1]; end
      5'd9: begin p = 128'(x) * 128'(y); r = p[63:0] & mask; of = ((p >> w) != 0); end
      5'd10: begin
        if (y == 0) begin r = mask; df = 1'b1; end
        else r = x / y;
      end
      default: ;
    endcase
  endtask

  // Launch one op on the chosen instance, scramble the inputs after acceptance, wait for listo.
  task automatic run_op(input int w, input logic [4:0] op, input logic [63:0] x, input logic [63:0] y,
                        output int lat, output logic [63:0] r, output logic [4:0] f);
    @(posedge clk); #1;
    if (w == 32) begin inicio = 1'b1; opcode = op; a = x[31:0]; b = y[31:0]; end
    else begin inicio8 = 1'b1; opcode8 = op; a8 = x[7:0]; b8 = y[7:0]; end
    @(posedge clk); #1;
    inicio = 1'b0; inicio8 = 1'b0;
    a = $urandom; b = $urandom; opcode = 5'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); opcode8 = 5'($urandom);
    lat = 1;
    while ((((w == 32) ? listo : listo8) !== 1'b1) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (w == 32) begin r = {32'd0, res}; f = {c, s, o, z, dz}; end
    else begin r = {56'd0, res8}; f = {c8, s8, o8, z8, dz8}; end
  endtask

  task automatic test_reset();
    reset = 1'b1; inicio = 1'b1; inicio8 = 1'b1; opcode = 5'd1; opcode8 = 5'd1;
    a = 32'h1; b = 32'h1; a8 = 8'h1; b8 = 8'h1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ocup, listo, c, s, o, z, dz} !== 7'b0 || res !== 32'd0) begin
      errors++;
      $display("FAIL reset32 ctl/flags=%b res=%h required 0000000 / 00000000", {ocup, listo, c, s, o, z, dz}, res);
    end
    checks++;
    if ({ocup8, listo8, c8, s8, o8, z8, dz8} !== 7'b0 || res8 !== 8'd0) begin
      errors++;
      $display("FAIL reset8 ctl/flags=%b res=%h required 0000000 / 00", {ocup8, listo8, c8, s8, o8, z8, dz8}, res8);
    end
    inicio = 1'b0; inicio8 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    int          w;
    logic [4:0]  op;
    logic [63:0] x, y, r;
    logic [4:0]  f;   // {C,S,O,Z,div_cero}
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t        vt[11];
    int          lat;
    logic [63:0] r;
    logic [4:0]  f;
    vt[0]  = '{32, 5'd1,  64'h8000_0000, 64'h8000_0000, 64'h0000_0000, 5'b10110, 1};
    vt[1]  = '{32, 5'd2,  64'h0000_0000, 64'h0000_0001, 64'hFFFF_FFFF, 5'b11000, 1};
    vt[2]  = '{32, 5'd7,  64'h8000_0001, 64'h0000_0001, 64'h0000_0002, 5'b10000, 1};
    vt[3]  = '{32, 5'd9,  64'h7,         64'h6,         64'h0000_002A, 5'b00000, 33};
    vt[4]  = '{32, 5'd9,  64'h0001_0000, 64'h0001_0000, 64'h0000_0000, 5'b00110, 33};
    vt[5]  = '{32, 5'd10, 64'd100,       64'd7,         64'h0000_000E, 5'b00000, 33};
    vt[6]  = '{32, 5'd10, 64'd5,         64'd0,         64'hFFFF_FFFF, 5'b01001, 1};
    vt[7]  = '{32, 5'd0,  64'd5,         64'd3,         64'h0,         5'b00010, 1};
    vt[8]  = '{32, 5'd20, 64'hFFFF_FFFF, 64'h1,         64'h0,         5'b00010, 1};
    vt[9]  = '{8,  5'd1,  64'hFF,        64'h01,        64'h00,        5'b10010, 1};
    vt[10] = '{8,  5'd9,  64'h10,        64'h10,        64'h00,        5'b00110, 9};
    for (int i = 0; i < 11; i++) begin
      run_op(vt[i].w, vt[i].op, vt[i].x, vt[i].y, lat, r, f);
      checks++;
      if (r !== vt[i].r || f !== vt[i].f || lat !== vt[i].lat) begin
        errors++;
        $display("FAIL directed[%0d] res=%h flags=%b lat=%0d required res=%h flags=%b lat=%0d",
                 i, r, f, lat, vt[i].r, vt[i].f, vt[i].lat);
      end
    end
  endtask

  task automatic test_random();
    int          w, lat, exp_lat;
    logic [4:0]  op, f, ef;
    logic [63:0] x, y, r, er, mask;
    logic        cf, of, df;
    for (int i = 0; i < 60; i++) begin
      w    = (i % 4 == 3) ? 8 : 32;
      mask = (64'd1 << w) - 64'd1;
      op   = (i % 3 == 0) ? 5'($urandom_range(9, 10)) : 5'($urandom_range(0, 31));
      x    = {$urandom, $urandom} & mask;
      y    = {$urandom, $urandom} & mask;
      if ($urandom_range(0, 7) == 0) y = '0;
      model(w, op, x, y, er, cf, of, df);
      ef      = {cf, er[w-1], of, (er == 0), df};
      exp_lat = (op == 5'd9 || (op == 5'd10 && y != 0)) ? w + 1 : 1;
      run_op(w, op, x, y, lat, r, f);
      checks++;
      if (r !== er) begin
        errors++;
        $display("FAIL rand_res w=%0d op=%0d a=%h b=%h got %h required %h", w, op, x, y, r, er);
      end
      checks++;
      if (f !== ef) begin
        errors++;
        $display("FAIL rand_flags w=%0d op=%0d a=%h b=%h got CSOZD=%b required %b", w, op, x, y, f, ef);
      end
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL rand_lat w=%0d op=%0d got %0d required %0d", w, op, lat, exp_lat);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int          lat;
    logic [63:0] er;
    logic        cf, of, df;
    model(32, 5'd9, 64'h1234, 64'h5678, er, cf, of, df);
    @(posedge clk); #1;
    inicio = 1'b1; opcode = 5'd9; a = 32'h1234; b = 32'h5678;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ocup !== 1'b1) begin
      errors++;
      $display("FAIL busy_ocupado got %b required 1", ocup);
    end
    inicio = 1'b1; opcode = 5'd1; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    inicio = 1'b0;
    lat = 6;
    while (listo !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 33 || res !== er[31:0] || o !== of) begin
      errors++;
      $display("FAIL busy_mul lat=%0d res=%h O=%b required lat=33 res=%h O=%b", lat, res, o, er[31:0], of);
    end
    inicio = 1'b1; opcode = 5'd1; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    inicio = 1'b0;
    checks++;
    if (listo !== 1'b0 || ocup !== 1'b0 || res !== er[31:0]) begin
      errors++;
      $display("FAIL fin_ignore listo=%b ocupado=%b res=%h required 0 0 %h", listo, ocup, res, er[31:0]);
    end
    a = $urandom; b = $urandom;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (res !== er[31:0] || listo !== 1'b0) begin
      errors++;
      $display("FAIL hold res=%h listo=%b required %h 0", res, listo, er[31:0]);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(posedge clk); #1;
    inicio = 1'b1; opcode = 5'd10; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({ocup, listo, c, s, o, z, dz} !== 7'b0 || res !== 32'd0) begin
      errors++;
      $display("FAIL abort_state ctl/flags=%b res=%h required 0000000 / 00000000", {ocup, listo, c, s, o, z, dz}, res);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (listo === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || res !== 32'd0) begin
      errors++;
      $display("FAIL abort_nolisto pulses=%0d res=%h required 0 00000000", seen, res);
    end
  endtask

  initial begin
    reset = 1'b1; inicio = 1'b0; inicio8 = 1'b0; opcode = '0; opcode8 = '0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_multiciclo.md
ALU_MULTICICLO -- requirements
Module: alu_multiciclo

Interface
REQ-001 The block SHALL have parameter ANCHO, default 32, giving the operand/result width in bits (legal: 8..64, even).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 inicio  input  1  request; accepted only when ocupado=0.
REQ-006 opcode  input  5  operation select.
REQ-007 operando_a  input  ANCHO  first operand.
REQ-008 operando_b  input  ANCHO  second operand or shift amount.
REQ-009 ocupado  output  1  high while an accepted operation is in progress.
REQ-010 listo  output  1  one-cycle pulse when resultado and flags become valid.
REQ-011 resultado  output  ANCHO  registered result.
REQ-012 C, S, O, Z  output  1 each  carry/borrow, sign, overflow, zero flags.
REQ-013 div_cero  output  1  set when a DIV had operando_b=0.

Function
REQ-014 Opcodes SHALL be: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOT=6, SHL=7, SHR=8, MUL=9, DIV=10; codes 11-31 SHALL behave as NOP.
REQ-015 Operands and opcode SHALL be captured on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-016 FSM states SHALL be REPOSO, CALCULO, FIN; reset enters REPOSO.
REQ-017 REPOSO + inicio with a single-cycle opcode (0-8, 11-31, or DIV with b=0) -> FIN; result and flags registered on that edge.
REQ-018 REPOSO + inicio with MUL, or DIV with b!=0 -> CALCULO; ocupado=1 from the next cycle.
REQ-019 CALCULO SHALL iterate exactly ANCHO cycles (MUL: shift-add; DIV: unsigned restoring), then -> FIN.
REQ-020 FIN SHALL assert listo for one cycle and return to REPOSO; ocupado=0 in FIN.
REQ-021 Latency: listo SHALL be high 1 cycle after acceptance for single-cycle ops, ANCHO+1 cycles for MUL/DIV.
REQ-022 inicio while ocupado=1 SHALL be ignored (no queueing); inicio in FIN SHALL be ignored.
REQ-023 resultado and flags SHALL hold their values until the next listo.
REQ-024 ADD/SUB: modulo 2^ANCHO; C=carry out (ADD) or borrow, i.e. a<b unsigned (SUB); O=two's-complement signed overflow.
REQ-025 AND/OR/XOR/NOT (NOT uses operando_a only): C=0, O=0.
REQ-026 SHL/SHR: logical, amount = operando_b[log2(ANCHO)-1:0]; C=last bit shifted out, 0 for amount 0; O=0.
REQ-027 MUL: unsigned; resultado=low ANCHO bits; O=1 iff high ANCHO bits nonzero; C=0.
REQ-028 DIV: unsigned quotient, remainder discarded; C=0, O=0; b=0 -> resultado all ones, div_cero=1, O=0.
REQ-029 div_cero SHALL clear on the next listo of any non-faulting operation.
REQ-030 For all ops S=resultado[ANCHO-1] and Z=(resultado==0); NOP -> resultado=0, C=O=0, Z=1.

Reset
REQ-031 On reset: state REPOSO; ocupado=0, listo=0, resultado=0, C=S=O=0, Z=0, div_cero=0.
REQ-032 Reset SHALL take priority over inicio and abort any CALCULO in progress with no listo pulse.

Verification
REQ-033 ADD 8000_0000+8000_0000 -> listo 1 cycle later; resultado=0, C=1, O=1, Z=1, S=0.
REQ-034 SUB 0000_0000-0000_0001 -> FFFF_FFFF, C=1, S=1, O=0, Z=0; SHL 8000_0001 by 1 -> 0000_0002, C=1.
REQ-035 MUL 7*6 -> listo on cycle 33, resultado=0000_002A, O=0; MUL 0001_0000*0001_0000 -> resultado=0, O=1, Z=1.
REQ-036 DIV 100/7 -> 0000_000E at cycle 33; DIV 5/0 -> FFFF_FFFF, div_cero=1, listo 1 cycle later.
REQ-037 inicio with ADD during cycle 5 of a MUL -> ignored, MUL result unchanged; reset during cycle 10 of DIV -> ocupado=0 next cycle, no listo, outputs at reset values.
REQ-038 ANCHO=8 build: ADD FF+01 -> 00, C=1, Z=1; MUL 10*10 -> 00, O=1, listo on cycle 9.
